// File: rtl/dot_product_mac_pkg.sv
// Shared definitions for the matrix-multiply datapath stages: FSM state
// encoding, default widths and counter-width helper.
package mm_defs;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_ACC  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_LEN    = 4;
  localparam int unsigned DEF_ACC_W  = 18;

  // Width of a counter that must hold values 0..n-1 (at least one bit).
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dot_product_mac_if.sv
// Operand and result handshake bundle for the dot-product MAC stage.
interface dot_product_mac_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 18
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  result;
  logic              overflow;

  // Upstream fetch / downstream writer side.
  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, result, overflow
  );

  // MAC side.
  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, result, overflow
  );
endinterface

// File: rtl/dot_product_mac_ripple_adder.sv
// Bit-level adder cells and an N-bit ripple-carry adder with carry-out.

// Half adder cell.
module half_adder (
  input  logic a_i,
  input  logic b_i,
  output logic sum_o,
  output logic cout_o
);
  assign sum_o  = a_i ^ b_i;
  assign cout_o = a_i & b_i;
endmodule

// Full adder built from two half-adder cells.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic cout_o
);
  logic s1, c1, c2;

  half_adder u_ha_ab  (.a_i(a_i), .b_i(b_i),   .sum_o(s1),    .cout_o(c1));
  half_adder u_ha_cin (.a_i(s1),  .b_i(cin_i), .sum_o(sum_o), .cout_o(c2));

  assign cout_o = c1 | c2;
endmodule

// N-bit ripple adder: bit 0 has no carry-in, so it uses a half adder.
module ripple_adder #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] sum_o,
  output logic         cout_o
);
  logic [N:1] carry;

  half_adder u_ha0 (.a_i(a_i[0]), .b_i(b_i[0]), .sum_o(sum_o[0]), .cout_o(carry[1]));

  for (genvar i = 1; i < N; i++) begin : g_fa
    full_adder u_fa (
      .a_i   (a_i[i]),
      .b_i   (b_i[i]),
      .cin_i (carry[i]),
      .sum_o (sum_o[i]),
      .cout_o(carry[i+1])
    );
  end

  assign cout_o = carry[N];
endmodule

// File: rtl/dot_product_mac.sv
// Sequential dot-product MAC: shift-and-add multiply per operand pair,
// accumulate LEN products, present the sum with a sticky carry-out flag.
module dot_product_mac
  import mm_defs::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned LEN    = DEF_LEN,
  parameter int unsigned ACC_W  = DEF_ACC_W
) (
  input  logic             clk,
  input  logic             rst,
  dot_product_mac_if.slave mac_if
);

  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned CNT_BW = cnt_w(DATA_W);
  localparam int unsigned CNT_EW = cnt_w(LEN);

  state_e              state_q, state_d;
  logic [PROD_W-1:0]   mcand_q, mcand_d;
  logic [DATA_W-1:0]   mplier_q, mplier_d;
  logic [PROD_W-1:0]   prod_q, prod_d;
  logic [CNT_BW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [CNT_EW-1:0]   elem_cnt_q, elem_cnt_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic                ovf_q, ovf_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;

  logic [PROD_W-1:0]   mul_sum;
  logic                unused_mul_cout;
  logic [ACC_W-1:0]    prod_ext;
  logic [ACC_W-1:0]    acc_sum;
  logic                acc_cout;

  assign prod_ext = ACC_W'(prod_q);

  // Partial-product adder; the product bound means it never carries out.
  ripple_adder #(.N(PROD_W)) u_mul_add (
    .a_i   (prod_q),
    .b_i   (mcand_q),
    .sum_o (mul_sum),
    .cout_o(unused_mul_cout)
  );

  // Accumulator adder; its carry-out feeds the sticky overflow flag.
  ripple_adder #(.N(ACC_W)) u_acc_add (
    .a_i   (acc_q),
    .b_i   (prod_ext),
    .sum_o (acc_sum),
    .cout_o(acc_cout)
  );

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mcand_q     <= '0;
      mplier_q    <= '0;
      prod_q      <= '0;
      bit_cnt_q   <= '0;
      elem_cnt_q  <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      prod_q      <= prod_d;
      bit_cnt_q   <= bit_cnt_d;
      elem_cnt_q  <= elem_cnt_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state, datapath update and registered handshake decodes.
  always_comb begin
    state_d    = state_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    prod_d     = prod_q;
    bit_cnt_d  = bit_cnt_q;
    elem_cnt_d = elem_cnt_q;
    acc_d      = acc_q;
    ovf_d      = ovf_q;

    case (state_q)
      ST_IDLE: begin
        if (mac_if.in_valid && in_ready_q) begin
          mcand_d   = PROD_W'(mac_if.a);
          mplier_d  = mac_if.b;
          prod_d    = '0;
          bit_cnt_d = '0;
          state_d   = ST_MUL;
        end
      end
      ST_MUL: begin
        if (mplier_q[0]) prod_d = mul_sum;
        mcand_d   = mcand_q << 1;
        mplier_d  = mplier_q >> 1;
        bit_cnt_d = bit_cnt_q + CNT_BW'(1);
        if (bit_cnt_q == CNT_BW'(DATA_W - 1)) state_d = ST_ACC;
      end
      ST_ACC: begin
        acc_d      = acc_sum;
        ovf_d      = ovf_q | acc_cout;
        elem_cnt_d = elem_cnt_q + CNT_EW'(1);
        state_d    = (elem_cnt_q == CNT_EW'(LEN - 1)) ? ST_DONE : ST_IDLE;
      end
      ST_DONE: begin
        if (mac_if.out_ready) begin
          acc_d      = '0;
          elem_cnt_d = '0;
          ovf_d      = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
  end

  assign mac_if.in_ready  = in_ready_q;
  assign mac_if.out_valid = out_valid_q;
  assign mac_if.result    = acc_q;
  assign mac_if.overflow  = ovf_q;

endmodule

// File: tb/tb_dot_product_mac.sv
// Bench for dot_product_mac: a default (ACC_W=18) and a narrow (ACC_W=16)
// instance see identical stimulus; expected results come from a vector table.
module tb_dot_product_mac;

  localparam int unsigned DW  = 8;
  localparam int unsigned LEN = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          out_ready;
  logic [DW-1:0] a;
  logic [DW-1:0] b;

  int n_checks = 0;
  int n_fail   = 0;

  dot_product_mac_if #(.DATA_W(DW), .ACC_W(18)) if18 ();
  dot_product_mac_if #(.DATA_W(DW), .ACC_W(16)) if16 ();

  assign if18.in_valid  = in_valid;
  assign if18.a         = a;
  assign if18.b         = b;
  assign if18.out_ready = out_ready;
  assign if16.in_valid  = in_valid;
  assign if16.a         = a;
  assign if16.b         = b;
  assign if16.out_ready = out_ready;

  dot_product_mac #(.DATA_W(DW), .LEN(LEN), .ACC_W(18)) u_dut18 (
    .clk   (clk),
    .rst   (rst),
    .mac_if(if18)
  );

  dot_product_mac #(.DATA_W(DW), .LEN(LEN), .ACC_W(16)) u_dut16 (
    .clk   (clk),
    .rst   (rst),
    .mac_if(if16)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0][7:0] va;
    logic [3:0][7:0] vb;
    logic [17:0]     r18;
    logic            o18;
    logic [15:0]     r16;
    logic            o16;
    int              hold;
  } vec_t;

  typedef struct {
    logic [17:0] r18;
    logic        o18;
    logic [15:0] r16;
    logic        o16;
    int          hold;
  } exp_t;

  vec_t vecs[7];
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Drive one pair, wait (bounded) for the handshake, then time the return
  // of in_ready (or out_valid after the last pair of a vector).
  task automatic send_pair(input logic [7:0] av, input logic [7:0] bv, input bit last);
    int n;
    @(negedge clk);
    a = av; b = bv; in_valid = 1'b1;
    n = 0;
    while (!if18.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("accept_wait_bounded", 32'(n < 100), 32'd1);
    @(posedge clk); #1;
    check("in_ready_low_after_accept", 32'(if18.in_ready), 32'd0);
    n = 0;
    while (!(last ? if18.out_valid : if18.in_ready) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check(last ? "out_valid_latency" : "in_ready_latency", 32'(n), 32'(DW + 1));
    check("narrow_timing_match", 32'(last ? if16.out_valid : if16.in_ready), 32'd1);
  endtask

  // Pop the scoreboard, compare both instances, apply backpressure, release.
  task automatic collect_result();
    exp_t e;
    check("scoreboard_nonempty", 32'(sb.size() > 0), 32'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    check("result18",   32'(if18.result),   32'(e.r18));
    check("overflow18", 32'(if18.overflow), 32'(e.o18));
    check("result16",   32'(if16.result),   32'(e.r16));
    check("overflow16", 32'(if16.overflow), 32'(e.o16));
    for (int h = 0; h < e.hold; h++) begin
      @(negedge clk);
      a = 8'($urandom); b = 8'($urandom); in_valid = 1'b1;
      @(posedge clk); #1;
      check("bp_out_valid",   32'(if18.out_valid), 32'd1);
      check("bp_in_ready",    32'(if18.in_ready),  32'd0);
      check("bp_result_hold", 32'(if18.result),    32'(e.r18));
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("post_hs_out_valid",   32'(if18.out_valid), 32'd0);
    check("post_hs_in_ready",    32'(if18.in_ready),  32'd1);
    check("post_hs_out_valid16", 32'(if16.out_valid), 32'd0);
  endtask

  task automatic send_vector(input int idx);
    exp_t e;
    e.r18 = vecs[idx].r18; e.o18 = vecs[idx].o18;
    e.r16 = vecs[idx].r16; e.o16 = vecs[idx].o16;
    e.hold = vecs[idx].hold;
    sb.push_back(e);
    for (int i = 0; i < 4; i++) send_pair(vecs[idx].va[i], vecs[idx].vb[i], i == 3);
    collect_result();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{va: {8'd4, 8'd3, 8'd2, 8'd1}, vb: {8'd8, 8'd7, 8'd6, 8'd5},
                r18: 18'd70, o18: 1'b0, r16: 16'd70, o16: 1'b0, hold: 0};
    vecs[1] = '{va: {4{8'd255}}, vb: {4{8'd255}},
                r18: 18'd260100, o18: 1'b0, r16: 16'd63492, o16: 1'b1, hold: 5};
    vecs[2] = '{va: {4{8'd1}}, vb: {4{8'd2}},
                r18: 18'd8, o18: 1'b0, r16: 16'd8, o16: 1'b0, hold: 0};
    vecs[3] = '{va: {4{8'd0}}, vb: {4{8'd255}},
                r18: 18'd0, o18: 1'b0, r16: 16'd0, o16: 1'b0, hold: 1};
    vecs[4] = '{va: {8'd25, 8'd50, 8'd100, 8'd200}, vb: {8'd13, 8'd11, 8'd7, 8'd3},
                r18: 18'd2175, o18: 1'b0, r16: 16'd2175, o16: 1'b0, hold: 0};
    vecs[5] = '{va: {8'd0, 8'd255, 8'd255, 8'd255}, vb: {8'd7, 8'd255, 8'd255, 8'd255},
                r18: 18'd195075, o18: 1'b0, r16: 16'd64003, o16: 1'b1, hold: 2};
    vecs[6] = '{va: {4{8'd1}}, vb: {4{8'd1}},
                r18: 18'd4, o18: 1'b0, r16: 16'd4, o16: 1'b0, hold: 0};

    // Reset held 3 cycles with in_valid asserted: no handshake may be taken.
    rst = 1'b1; in_valid = 1'b1; a = 8'd3; b = 8'd3; out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("rst_in_ready",  32'(if18.in_ready),  32'd1);
      check("rst_out_valid", 32'(if18.out_valid), 32'd0);
      check("rst_overflow",  32'(if18.overflow),  32'd0);
      check("rst_result",    32'(if18.result),    32'd0);
    end
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    check("post_rst_in_ready",  32'(if18.in_ready),  32'd1);
    check("post_rst_out_valid", 32'(if16.out_valid), 32'd0);

    for (int v = 0; v < 6; v++) send_vector(v);

    // Reset during MUL of the third pair abandons the partial vector.
    send_pair(8'd9, 8'd9, 1'b0);
    send_pair(8'd9, 8'd9, 1'b0);
    @(negedge clk);
    a = 8'd7; b = 8'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    check("third_pair_accepted", 32'(if18.in_ready), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    check("midrst_in_ready",  32'(if18.in_ready),  32'd1);
    check("midrst_result",    32'(if18.result),    32'd0);
    check("midrst_out_valid", 32'(if18.out_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("midrst_idle_after", 32'(if18.in_ready), 32'd1);
    send_vector(6);

    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
